film_frame_writer: RTL and testbench
====================================

# film_frame_writer

Downstream sink for the pixel-processing stages (negative film and its siblings). It accepts the processed 24-bit RGB stream with its `valid` qualifier and writes each pixel into a WIDTH×HEIGHT frame buffer RAM in raster order. It keeps per-channel sums for grading, flags excess pixels, and signals frame completion to the top-level controller.

## Interface
Parameters:
- WIDTH, 256, pixels per row
- HEIGHT, 256, rows per frame
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pixel_in  in  24  {R[23:16], G[15:8], B[7:0]} from the upstream stage
- valid_in  in  1  pixel_in is a real pixel this cycle
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM write address (row*WIDTH + col)
- mem_wdata  out  24  RAM write data
- sum_r, sum_g, sum_b  out  ADDR_W+8 each  per-channel sums over the current frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- busy  out  1  frame capture in progress
- overrun  out  1  sticky; a pixel arrived while in DONE

## Operation
- FSM states are IDLE, CAPTURE and DONE. The state register resets to IDLE.
- IDLE:
  - busy=0.
  - valid_in=1 → write the pixel at address 0, clear the sums and load them with this pixel, set col=1, go to CAPTURE. If WIDTH*HEIGHT==1, go directly to DONE.
- CAPTURE:
  - busy=1.
  - Each valid_in=1 cycle → write at row*WIDTH+col, add each channel to its sum, advance col.
  - When col=WIDTH-1, col wraps to 0 and row increments.
  - valid_in=0 cycles (gaps) → no write; counters and sums hold. Gaps may be of any length.
  - When the accepted pixel is number WIDTH*HEIGHT (row=HEIGHT-1, col=WIDTH-1) → go to DONE.
- DONE:
  - Lasts one cycle. busy=0, frame_done=1.
  - Counters clear to 0. Sums hold their final values until the next frame starts.
  - valid_in=1 in this cycle → pixel dropped (no write) and overrun set.
  - Always returns to IDLE.
- A valid_in in IDLE that follows DONE starts a new frame. overrun stays set until rst.
- Arithmetic:
  - Sums are unsigned and zero-extend the 8-bit channels.
  - ADDR_W+8 bits holds 255*65536 with no overflow, so sums never wrap in range.
- Reset mid-frame (rst=1 in any state):
  - State goes to IDLE; counters, sums and overrun clear; all outputs go to their reset values on the next edge.
  - The partial frame is abandoned and no frame_done is issued.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, sum_r/g/b=0, frame_done=0, busy=0, overrun=0.
- All outputs are registered.
- Latency: valid_in sampled at edge N → mem_we/mem_addr/mem_wdata valid after edge N+1 for exactly one cycle. Sums include that pixel in the same cycle.
- frame_done rises one cycle after the final pixel's mem_we cycle.
- Throughput: one pixel per cycle sustained. Back-to-back frames are allowed; exactly one pixel can be lost, the one arriving during the DONE cycle, and it is flagged by overrun.
- mem_we is never high in IDLE-entry-from-reset or DONE cycles.

## Structure
- Shared package film_pkg:
  - pixel type (24-bit RGB struct/width constants)
  - default IMG_W/IMG_H = 256
  - the FSM state encoding, shared with the other film stages
- One natural sub-module: raster_addr_gen, containing the col/row counters, wrap logic, last-pixel flag and address multiply. Keep the multiply as a shift when WIDTH is a power of two.
- FSM, sums and overrun stay in the top-level module.

## Test plan
- Full frame, continuous valid: pixels value i (24-bit) for i=0..65535.
  - Expect 65536 writes with mem_addr=i and mem_wdata=i.
  - Expect frame_done exactly one cycle after address 65535 is written.
  - Expect sum_b = Σ(i mod 256) = 8355840.
- Gapped stream: valid toggles 1,0,0,1… over a full frame.
  - Expect addresses contiguous 0..65535 with no write in gap cycles.
  - Expect frame_done once, and busy=1 throughout capture.
- Constant 24'hFFFFFF for a full frame → sum_r = sum_g = sum_b = 16711680, overrun=0.
- Overrun: valid held high through the end of frame.
  - The pixel in the DONE cycle is not written and overrun=1.
  - The next pixel starts frame 2 at address 0.
  - overrun stays 1 until rst.
- Reset mid-frame: rst for one cycle after 1000 pixels.
  - Expect all outputs to reach their reset values; no frame_done.
  - The following frame starts at address 0 with sums from 0.
- Small parameters: WIDTH=4, HEIGHT=2.
  - Expect the column wrap at col 3 → row 1, addresses 0..7.
  - Expect frame_done after the 8th pixel.

Source files
------------

// File: rtl/film_pkg.sv
// Shared types for the film pixel-processing stages: pixel layout,
// default image geometry and the common three-state FSM encoding.
package film_pkg;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int CH_W  = 8;
  localparam int PIX_W = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    FILM_IDLE    = 2'd0,
    FILM_CAPTURE = 2'd1,
    FILM_DONE    = 2'd2
  } film_state_e;

  // Lets geometry-dependent logic pick a shift instead of a multiply.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/film_frame_writer_raster_addr_gen.sv
// Raster position tracker: column/row counters with wrap, last-pixel flag
// and the linear RAM address of the current position.
module raster_addr_gen
  import film_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,   // a pixel was accepted at the current position
  input  logic              clr,   // return to the top-left corner
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

  // Next position: clear wins, otherwise step one column and wrap into the next row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // row*WIDTH+col; a power-of-two width reduces to a shift-and-or.
  generate
    if (is_pow2(WIDTH)) begin : g_shift
      assign addr = (ADDR_W'(row_q) << $clog2(WIDTH)) | ADDR_W'(col_q);
    end else begin : g_mult
      assign addr = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
    end
  endgenerate

endmodule

// File: rtl/film_frame_writer.sv
// Frame sink: writes the processed RGB stream into the frame buffer in
// raster order, keeps per-channel sums, reports completion and overruns.
module film_frame_writer
  import film_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       pixel_in,
  input  logic              valid_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic [ADDR_W+7:0] sum_r,
  output logic [ADDR_W+7:0] sum_g,
  output logic [ADDR_W+7:0] sum_b,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun
);

  localparam int SW = ADDR_W + 8;

  film_state_e       state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [23:0]       mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]     sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              adv, clr, pos_last;
  logic [ADDR_W-1:0] pos_addr;
  pixel_t            px;

  assign px = pixel_t'(pixel_in);

  raster_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .clr (clr),
    .addr(pos_addr),
    .last(pos_last)
  );

  // FSM next state plus the write/sum/flag updates that go with each state.
  // frame_done is registered off the DONE state, so it lands one cycle after
  // the final write; a pixel offered during DONE is dropped and flagged.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sum_r_d      = sum_r_q;
    sum_g_d      = sum_g_q;
    sum_b_d      = sum_b_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    adv          = 1'b0;
    clr          = 1'b0;
    case (state_q)
      FILM_IDLE: begin
        if (valid_in) begin
          adv         = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = pos_addr;
          mem_wdata_d = pixel_in;
          sum_r_d     = SW'(px.r);
          sum_g_d     = SW'(px.g);
          sum_b_d     = SW'(px.b);
          state_d     = pos_last ? FILM_DONE : FILM_CAPTURE;
        end
      end
      FILM_CAPTURE: begin
        if (valid_in) begin
          adv         = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = pos_addr;
          mem_wdata_d = pixel_in;
          sum_r_d     = sum_r_q + SW'(px.r);
          sum_g_d     = sum_g_q + SW'(px.g);
          sum_b_d     = sum_b_q + SW'(px.b);
          if (pos_last) state_d = FILM_DONE;
        end
      end
      FILM_DONE: begin
        clr          = 1'b1;
        frame_done_d = 1'b1;
        if (valid_in) overrun_d = 1'b1;
        state_d      = FILM_IDLE;
      end
      default: begin
        clr     = 1'b1;
        state_d = FILM_IDLE;
      end
    endcase
    busy_d = (state_d == FILM_CAPTURE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILM_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      sum_r_q      <= '0;
      sum_g_q      <= '0;
      sum_b_q      <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sum_r_q      <= sum_r_d;
      sum_g_q      <= sum_g_d;
      sum_b_q      <= sum_b_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign sum_r      = sum_r_q;
  assign sum_g      = sum_g_q;
  assign sum_b      = sum_b_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_film_frame_writer.sv
// Bench: two writers (24x20 multiply-addressed, 4x2 shift-addressed) share
// one input stream and are checked every cycle against a per-frame model.
module tb_film_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel_in;
  logic        valid_in;

  logic        a_we, a_fd, a_busy, a_ovr;
  logic [8:0]  a_addr;
  logic [23:0] a_wd;
  logic [16:0] a_sr, a_sg, a_sb;

  logic        b_we, b_fd, b_busy, b_ovr;
  logic [2:0]  b_addr;
  logic [23:0] b_wd;
  logic [10:0] b_sr, b_sg, b_sb;

  int vectors = 0;
  int miscompares = 0;

  // model state, index 0 = 24x20 unit, 1 = 4x2 unit
  int          np [2] = '{480, 8};
  int          cnt [2];
  bit          dslot [2];
  bit          ovr [2];
  int          sr [2], sg [2], sb [2];
  bit          e_we [2], e_fd [2], e_busy [2];
  int          e_addr [2];
  logic [23:0] e_wd [2];

  always #5 clk = ~clk;

  film_frame_writer #(.WIDTH(24), .HEIGHT(20), .ADDR_W(9)) dut_a (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
    .sum_r(a_sr), .sum_g(a_sg), .sum_b(a_sb),
    .frame_done(a_fd), .busy(a_busy), .overrun(a_ovr)
  );

  film_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
    .sum_r(b_sr), .sum_g(b_sg), .sum_b(b_sb),
    .frame_done(b_fd), .busy(b_busy), .overrun(b_ovr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: pixel k of a frame goes to address k; the slot
  // right after the last pixel is the done slot, where input is dropped.
  task automatic model(input int d, input bit r, input bit v, input logic [23:0] p);
    if (r) begin
      cnt[d] = 0; dslot[d] = 0; ovr[d] = 0;
      sr[d] = 0; sg[d] = 0; sb[d] = 0;
      e_we[d] = 0; e_fd[d] = 0; e_busy[d] = 0; e_addr[d] = 0; e_wd[d] = '0;
    end else if (dslot[d]) begin
      dslot[d] = 0; cnt[d] = 0;
      e_we[d] = 0; e_fd[d] = 1; e_busy[d] = 0;
      if (v) ovr[d] = 1;
    end else if (v) begin
      if (cnt[d] == 0) begin
        sr[d] = 0; sg[d] = 0; sb[d] = 0;
      end
      sr[d] += int'(p[23:16]);
      sg[d] += int'(p[15:8]);
      sb[d] += int'(p[7:0]);
      e_we[d] = 1; e_fd[d] = 0; e_addr[d] = cnt[d]; e_wd[d] = p;
      cnt[d]++;
      if (cnt[d] == np[d]) begin
        dslot[d] = 1; e_busy[d] = 0;
      end else begin
        e_busy[d] = 1;
      end
    end else begin
      e_we[d] = 0; e_fd[d] = 0; e_busy[d] = (cnt[d] > 0);
    end
  endtask

  task automatic check_all();
    chk("A.mem_we",     64'(a_we),   64'(e_we[0]));
    chk("A.mem_addr",   64'(a_addr), 64'(e_addr[0]));
    chk("A.mem_wdata",  64'(a_wd),   64'(e_wd[0]));
    chk("A.sum_r",      64'(a_sr),   64'(sr[0]));
    chk("A.sum_g",      64'(a_sg),   64'(sg[0]));
    chk("A.sum_b",      64'(a_sb),   64'(sb[0]));
    chk("A.frame_done", 64'(a_fd),   64'(e_fd[0]));
    chk("A.busy",       64'(a_busy), 64'(e_busy[0]));
    chk("A.overrun",    64'(a_ovr),  64'(ovr[0]));
    chk("B.mem_we",     64'(b_we),   64'(e_we[1]));
    chk("B.mem_addr",   64'(b_addr), 64'(e_addr[1]));
    chk("B.mem_wdata",  64'(b_wd),   64'(e_wd[1]));
    chk("B.sum_r",      64'(b_sr),   64'(sr[1]));
    chk("B.sum_g",      64'(b_sg),   64'(sg[1]));
    chk("B.sum_b",      64'(b_sb),   64'(sb[1]));
    chk("B.frame_done", 64'(b_fd),   64'(e_fd[1]));
    chk("B.busy",       64'(b_busy), 64'(e_busy[1]));
    chk("B.overrun",    64'(b_ovr),  64'(ovr[1]));
  endtask

  task automatic step(input bit r, input bit v, input logic [23:0] p);
    rst = r; valid_in = v; pixel_in = p;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model(d, r, v, p);
    check_all();
  endtask

  initial begin
    logic [23:0] p;
    rst = 1'b1; valid_in = 1'b0; pixel_in = '0;

    // reset state
    step(1, 0, '0);
    step(1, 0, '0);

    // full frame, continuous valid, pixel value = index
    for (int i = 0; i < 480; i++) begin
      p = 24'(i);
      step(0, 1, p);
    end
    step(0, 0, '0);
    step(0, 0, '0);
    chk("A.sum_b_full", 64'(a_sb), 64'd57616);

    // gapped stream 1,0,0,...
    step(1, 0, '0);
    for (int i = 0; i < 480 * 3 + 6; i++) begin
      p = 24'($urandom);
      step(0, (i % 3) == 0, p);
    end

    // constant white frame
    step(1, 0, '0);
    for (int i = 0; i < 480; i++) step(0, 1, 24'hFFFFFF);
    step(0, 0, '0);
    chk("A.sum_r_white", 64'(a_sr), 64'd122400);
    chk("A.sum_g_white", 64'(a_sg), 64'd122400);
    chk("A.sum_b_white", 64'(a_sb), 64'd122400);
    chk("A.ovr_white",   64'(a_ovr), 64'd0);

    // overrun: valid held through the end of frame and into frame 2
    step(1, 0, '0);
    for (int i = 0; i < 480 + 20; i++) begin
      p = 24'($urandom);
      step(0, 1, p);
    end
    chk("A.ovr_set", 64'(a_ovr), 64'd1);
    for (int i = 0; i < 200; i++) begin
      p = 24'($urandom);
      step(0, ($urandom % 2) == 0, p);
    end
    chk("A.ovr_sticky", 64'(a_ovr), 64'd1);

    // reset mid-frame
    for (int i = 0; i < 100; i++) begin
      p = 24'($urandom);
      step(0, 1, p);
    end
    step(1, 1, 24'h123456);
    chk("A.ovr_cleared", 64'(a_ovr), 64'd0);
    for (int i = 0; i < 60; i++) begin
      p = 24'($urandom);
      step(0, 1, p);
    end

    // random traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      p = 24'($urandom);
      step(($urandom % 700) == 0, ($urandom % 4) != 0, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
